// File: rtl/mul_iter_32b.sv
`default_nettype none
// ============================================================================
//  Module      : mul_iter_32b
//  Description : Iterative 32x32 shift-add multiplier for the TinyRV1 `mul`
//                instruction. Accepts one operand bundle at a time over a
//                val/rdy handshake, computes the low 32 bits of in0*in1 and
//                returns it together with the carried destination address.
//
//  Ports:
//    clk          in   1   clock, all state updates on rising edge
//    reset        in   1   synchronous, active-high
//    istream_val  in   1   operand bundle valid
//    istream_rdy  out  1   unit can accept an operand bundle (IDLE only)
//    in0          in   32  multiplicand
//    in1          in   32  multiplier
//    waddr_in     in   5   destination register address
//    ostream_val  out  1   result valid (DONE only)
//    ostream_rdy  in   1   consumer can take result
//    result       out  32  low 32 bits of in0*in1 (0 outside DONE)
//    waddr_out    out  5   destination address for result (0 outside DONE)
//
//  Build option:
//    MUL_EARLY_EXIT_EN  when defined, CALC ends as soon as the remaining
//                       multiplier bits are all zero; result is unchanged.
//
//  Revision    : 1.0  initial release
// ============================================================================
module mul_iter_32b (
    input  logic        clk,
    input  logic        reset,
    input  logic        istream_val,
    output logic        istream_rdy,
    input  logic [31:0] in0,
    input  logic [31:0] in1,
    input  logic [4:0]  waddr_in,
    output logic        ostream_val,
    input  logic        ostream_rdy,
    output logic [31:0] result,
    output logic [4:0]  waddr_out
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [5:0] c_LAST_CNT = 6'd31;

    state_t      r_state;
    state_t      w_state_next;

    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_acc;
    logic [5:0]  r_cnt;
    logic [4:0]  r_waddr;

    logic [31:0] w_b_shift;
    logic        w_last_iter;
    logic        w_in_fire;

    assign w_b_shift = r_b >> 1;

`ifdef MUL_EARLY_EXIT_EN
    // Once the shifted multiplier is zero no further partial products can
    // be added, so the accumulator already holds the final value.
    assign w_last_iter = (r_cnt == c_LAST_CNT) || (w_b_shift == 32'd0);
`else
    assign w_last_iter = (r_cnt == c_LAST_CNT);
`endif

    // Handshake outputs depend on state only; reset masks them so nothing
    // is offered or accepted during a reset cycle.
    assign istream_rdy = (r_state == S_IDLE) && !reset;
    assign ostream_val = (r_state == S_DONE) && !reset;
    assign result      = ostream_val ? r_acc   : 32'd0;
    assign waddr_out   = ostream_val ? r_waddr : 5'd0;

    assign w_in_fire   = istream_val && istream_rdy;

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: if (w_in_fire)   w_state_next = S_CALC;
            S_CALC: if (w_last_iter) w_state_next = S_DONE;
            S_DONE: if (ostream_rdy) w_state_next = S_IDLE;
            default:                 w_state_next = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: shift-add, one multiplier bit per CALC cycle
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_a     <= 32'd0;
            r_b     <= 32'd0;
            r_acc   <= 32'd0;
            r_cnt   <= 6'd0;
            r_waddr <= 5'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_in_fire) begin
                        r_a     <= in0;
                        r_b     <= in1;
                        r_acc   <= 32'd0;
                        r_cnt   <= 6'd0;
                        r_waddr <= waddr_in;
                    end
                end
                S_CALC: begin
                    if (r_b[0]) begin
                        r_acc <= r_acc + r_a;
                    end
                    r_a   <= r_a << 1;
                    r_b   <= w_b_shift;
                    r_cnt <= r_cnt + 6'd1;
                end
                default: begin
                    // DONE holds everything until the result is taken.
                end
            endcase
        end
    end

endmodule
`default_nettype wire
